// File: rtl/spram_arbiter.sv
// spram_arbiter
// Shares one iCE40 SB_SPRAM256KA (16K x 16) between the capture write port
// and the host read port. Single-word accesses, write priority with read
// aging, and automatic standby of the SPRAM after a programmable idle time.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_req/addr/data/mask write request side (held until wr_gnt)
//   wr_gnt                write accepted this cycle
//   rd_req/addr           read request side (held until rd_gnt)
//   rd_gnt                read accepted this cycle
//   rd_data, rd_valid     read data, valid one cycle after rd_gnt
//   ram_*                 SPRAM ADDRESS/DATAIN/MASKWREN/WREN/CHIPSELECT/STANDBY
//   ram_dout              SPRAM DATAOUT
//
// Optional feature (define SPRAM_ARB_STATS_EN):
//   stall_clr             synchronous clear of stall_cnt
//   stall_cnt             saturating count of cycles with a request pending
//                         but nothing granted
module spram_arbiter #(
  parameter int AW           = 14,
  parameter int DW           = 16,
  parameter int MAX_WAIT     = 4,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [3:0]    wr_mask,
  output logic          wr_gnt,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
`ifdef SPRAM_ARB_STATS_EN
  input  logic          stall_clr,
  output logic [15:0]   stall_cnt,
`endif
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic [3:0]    ram_maskwren,
  output logic          ram_wren,
  output logic          ram_cs,
  output logic          ram_standby,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    STANDBY = 2'd1,
    WAKE    = 2'd2
  } state_t;

  localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LAST = (IDLE_TIMEOUT > 0) ? IW'(IDLE_TIMEOUT - 1) : '0;

  state_t        state, state_nxt;
  logic [3:0]    rd_wait_cnt;
  logic [IW-1:0] idle_cnt;
  logic          any_req;
  logic          rd_aged;

  assign any_req = wr_req | rd_req;
  assign rd_aged = (rd_wait_cnt >= 4'(MAX_WAIT));

  // Next state and grants. Grants are gated by rst_n so that while reset is
  // held the SPRAM sees no access even if a requester keeps its line high.
  always_comb begin
    state_nxt   = state;
    wr_gnt      = 1'b0;
    rd_gnt      = 1'b0;
    ram_standby = 1'b0;
    case (state)
      ACTIVE: begin
        if (rst_n) begin
          if (wr_req && !(rd_req && rd_aged)) begin
            wr_gnt = 1'b1;
          end else if (rd_req) begin
            rd_gnt = 1'b1;
          end
        end
        if (!any_req && (IDLE_TIMEOUT != 0) && (idle_cnt == IDLE_LAST)) begin
          state_nxt = STANDBY;
        end
      end
      STANDBY: begin
        ram_standby = 1'b1;
        if (any_req) begin
          state_nxt = WAKE;
        end
      end
      WAKE: begin
        state_nxt = ACTIVE;
      end
      default: begin
        state_nxt = ACTIVE;
      end
    endcase
  end

  // SPRAM pins follow the grant. The address mux falls back to rd_addr and
  // DATAIN always carries wr_data, so neither floats when nothing is granted.
  assign ram_cs       = wr_gnt | rd_gnt;
  assign ram_wren     = wr_gnt;
  assign ram_addr     = wr_gnt ? wr_addr : rd_addr;
  assign ram_din      = wr_data;
  assign ram_maskwren = wr_gnt ? wr_mask : 4'b0000;
  assign rd_data      = ram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACTIVE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read aging, idle timer and read-valid pipeline. The idle timer restarts
  // from zero whenever the SPRAM is not in ACTIVE, so each wake-up gets a
  // full timeout before the next standby.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wait_cnt <= 4'd0;
      idle_cnt    <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= rd_gnt;

      if (rd_gnt) begin
        rd_wait_cnt <= 4'd0;
      end else if ((state == ACTIVE) && rd_req && (rd_wait_cnt != 4'hF)) begin
        rd_wait_cnt <= rd_wait_cnt + 1'b1;
      end

      if ((state != ACTIVE) || any_req || (state_nxt != ACTIVE)) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

`ifdef SPRAM_ARB_STATS_EN
  // Stall statistics: any pending request without a grant, which includes
  // every cycle spent in STANDBY or WAKE with a request waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (stall_clr) begin
      stall_cnt <= 16'd0;
    end else if (any_req && !ram_cs && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
